uart_brg_ctrl: RTL and testbench

UART_BRG_CTRL -- requirements
Module: uart_brg_ctrl

---
 rtl/uart_brg_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_brg_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_brg_ctrl.sv
// UART baud rate generator controller.
// Holds the active prescaler/divider, defers rate changes until both UART
// directions are idle, pulses a reset into the generator, then waits for the
// first 16x enable so the local 16x phase counter restarts aligned with it.
module uart_brg_ctrl #(
   parameter logic [3:0] pPS_Init  = 4'd1,
   parameter logic [7:0] pDiv_Init = 8'd12,
   parameter int         pRstLen   = 2
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       WE,
   input  logic [3:0] PS_In,
   input  logic [7:0] Div_In,
   input  logic       Idle,
   input  logic       CE_16x,
   output logic [3:0] PS,
   output logic [7:0] Div,
   output logic       BRG_Rst,
   output logic       Pend,
   output logic       Rdy,
   output logic       CE_1x
);

   localparam logic [3:0] RST_LEN_C = 4'(pRstLen);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PEND = 2'd1,
      ST_HOLD = 2'd2,
      ST_SYNC = 2'd3
   } state_t;

   state_t     state_r;
   state_t     state_next_s;
   logic       load_rate_s;
   logic       pend_next_s;
   logic [3:0] hold_cnt_r;
   logic [3:0] phase_r;
   logic [3:0] sh_ps_r;
   logic [7:0] sh_div_r;
   logic [3:0] ps_r;
   logic [7:0] div_r;
   logic       brg_rst_r;
   logic       pend_r;
   logic       rdy_r;
   logic       ce_1x_r;

   assign PS      = ps_r;
   assign Div     = div_r;
   assign BRG_Rst = brg_rst_r;
   assign Pend    = pend_r;
   assign Rdy     = rdy_r;
   assign CE_1x   = ce_1x_r;

   // Next-state decode; a rate is applied only on a PEND->HOLD move with no write racing it.
   always_comb begin
      state_next_s = state_r;
      load_rate_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (WE || pend_r) begin
               state_next_s = ST_PEND;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_PEND: begin
            if (Idle && !WE) begin
               state_next_s = ST_HOLD;
               load_rate_s  = 1'b1;
            end else begin
               state_next_s = ST_PEND;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_r <= 4'd1) begin
               state_next_s = ST_SYNC;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         ST_SYNC: begin
            // A write landing on the aligning pulse must not be lost, so it also counts as pending.
            if (CE_16x) begin
               if (pend_r || WE) begin
                  state_next_s = ST_PEND;
               end else begin
                  state_next_s = ST_RUN;
               end
            end else begin
               state_next_s = ST_SYNC;
            end
         end
         default: begin
            state_next_s = ST_HOLD;
         end
      endcase
   end

   // Pending flag: any write sets it, applying the shadow rate clears it.
   always_comb begin
      pend_next_s = pend_r;
      if (WE) begin
         pend_next_s = 1'b1;
      end else if (load_rate_s) begin
         pend_next_s = 1'b0;
      end else begin
         pend_next_s = pend_r;
      end
   end

   // State register and hold-length counter (reloaded on every HOLD entry).
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r    <= ST_HOLD;
         hold_cnt_r <= RST_LEN_C;
      end else begin
         state_r <= state_next_s;
         if ((state_next_s == ST_HOLD) && (state_r != ST_HOLD)) begin
            hold_cnt_r <= RST_LEN_C;
         end else if (state_r == ST_HOLD) begin
            hold_cnt_r <= hold_cnt_r - 4'd1;
         end else begin
            hold_cnt_r <= hold_cnt_r;
         end
      end
   end

   // Shadow and active rate registers; last write wins in the shadow.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         sh_ps_r  <= pPS_Init;
         sh_div_r <= pDiv_Init;
         ps_r     <= pPS_Init;
         div_r    <= pDiv_Init;
      end else begin
         if (WE) begin
            sh_ps_r  <= PS_In;
            sh_div_r <= Div_In;
         end
         if (load_rate_s) begin
            ps_r  <= sh_ps_r;
            div_r <= sh_div_r;
         end
      end
   end

   // Registered status outputs derived from the next state.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         brg_rst_r <= 1'b1;
         pend_r    <= 1'b0;
         rdy_r     <= 1'b0;
      end else begin
         brg_rst_r <= (state_next_s == ST_HOLD);
         pend_r    <= pend_next_s;
         rdy_r     <= (state_next_s == ST_RUN);
      end
   end

   // 16x phase counter and 1x enable; the old rate keeps ticking while a change is pending.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         phase_r <= 4'd0;
         ce_1x_r <= 1'b0;
      end else begin
         if (state_r == ST_HOLD) begin
            phase_r <= 4'd0;
         end else if (CE_16x) begin
            phase_r <= phase_r + 4'd1;
         end else begin
            phase_r <= phase_r;
         end
         ce_1x_r <= CE_16x && (phase_r == 4'd15) &&
                    ((state_r == ST_RUN) || (state_r == ST_PEND));
      end
   end

endmodule

// File: tb/tb_uart_brg_ctrl.sv
// Directed self-checking bench for uart_brg_ctrl.
module tb_uart_brg_ctrl;

   logic       Clk;
   logic       Rst;
   logic       WE;
   logic [3:0] PS_In;
   logic [7:0] Div_In;
   logic       Idle;
   logic       CE_16x;
   logic [3:0] PS;
   logic [7:0] Div;
   logic       BRG_Rst;
   logic       Pend;
   logic       Rdy;
   logic       CE_1x;

   int checks_r;
   int failures_r;
   int ce1x_cnt;
   int ce1x_pos1;
   int ce1x_pos2;

   uart_brg_ctrl #(
      .pPS_Init  (4'd1),
      .pDiv_Init (8'd12),
      .pRstLen   (2)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .WE      (WE),
      .PS_In   (PS_In),
      .Div_In  (Div_In),
      .Idle    (Idle),
      .CE_16x  (CE_16x),
      .PS      (PS),
      .Div     (Div),
      .BRG_Rst (BRG_Rst),
      .Pend    (Pend),
      .Rdy     (Rdy),
      .CE_1x   (CE_1x)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_r = checks_r + 1;
      if (act !== exp) begin
         failures_r = failures_r + 1;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock edge, then settle so registered outputs can be sampled.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic write_rate(input logic [3:0] ps_v, input logic [7:0] div_v);
      WE     = 1'b1;
      PS_In  = ps_v;
      Div_In = div_v;
      tick();
      WE     = 1'b0;
   endtask

   // One CE_16x pulse followed by a quiet cycle; records where CE_1x appears.
   task automatic pulse16(input int idx);
      CE_16x = 1'b1;
      tick();
      CE_16x = 1'b0;
      if (CE_1x) begin
         ce1x_cnt = ce1x_cnt + 1;
         if (ce1x_cnt == 1) ce1x_pos1 = idx;
         else ce1x_pos2 = idx;
      end
      tick();
      if (CE_1x) ce1x_cnt = ce1x_cnt + 100;
   endtask

   initial begin
      checks_r   = 0;
      failures_r = 0;
      Rst    = 1'b1;
      WE     = 1'b0;
      PS_In  = 4'd0;
      Div_In = 8'd0;
      Idle   = 1'b1;
      CE_16x = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_brg",  32'(BRG_Rst), 32'd1);
      chk("rst_ps",   32'(PS),      32'd1);
      chk("rst_div",  32'(Div),     32'd12);
      chk("rst_pend", 32'(Pend),    32'd0);
      chk("rst_rdy",  32'(Rdy),     32'd0);
      chk("rst_ce1x", 32'(CE_1x),   32'd0);

      // Power-up sequence: two HOLD cycles, then SYNC until a 16x pulse
      Rst = 1'b0;
      tick();
      chk("pu_brg_h", 32'(BRG_Rst), 32'd1);
      tick();
      chk("pu_brg_l", 32'(BRG_Rst), 32'd0);
      tick();
      tick();
      chk("pu_rdy0", 32'(Rdy), 32'd0);
      CE_16x = 1'b1;
      tick();
      CE_16x = 1'b0;
      chk("pu_rdy1", 32'(Rdy), 32'd1);
      chk("pu_ps",   32'(PS),  32'd1);
      chk("pu_div",  32'(Div), 32'd12);

      // 1x enable: phase is 1 after the aligning pulse, 15 pulses wrap it to 0
      ce1x_cnt = 0; ce1x_pos1 = 0; ce1x_pos2 = 0;
      for (int i = 1; i <= 15; i++) pulse16(i);
      chk("ce1x_wrap_cnt", 32'(ce1x_cnt),  32'd1);
      chk("ce1x_wrap_pos", 32'(ce1x_pos1), 32'd15);
      ce1x_cnt = 0; ce1x_pos1 = 0; ce1x_pos2 = 0;
      for (int i = 1; i <= 32; i++) pulse16(i);
      chk("ce1x_cnt",  32'(ce1x_cnt),  32'd2);
      chk("ce1x_pos1", 32'(ce1x_pos1), 32'd16);
      chk("ce1x_pos2", 32'(ce1x_pos2), 32'd32);

      // Rate change while idle: PEND one cycle, then HOLD for two cycles
      Idle = 1'b1;
      write_rate(4'd3, 8'h40);
      chk("chg_pend1", 32'(Pend),    32'd1);
      chk("chg_ps_old",32'(PS),      32'd1);
      chk("chg_rdy0",  32'(Rdy),     32'd0);
      tick();
      chk("chg_ps",    32'(PS),      32'd3);
      chk("chg_div",   32'(Div),     32'h40);
      chk("chg_brg2",  32'(BRG_Rst), 32'd1);
      chk("chg_pend0", 32'(Pend),    32'd0);
      tick();
      chk("chg_brg3",  32'(BRG_Rst), 32'd1);
      tick();
      chk("chg_brg4",  32'(BRG_Rst), 32'd0);
      CE_16x = 1'b1;
      tick();
      CE_16x = 1'b0;
      chk("chg_rdy1",  32'(Rdy), 32'd1);

      // Busy UART: two writes, last one wins once idle
      Idle = 1'b0;
      write_rate(4'd5, 8'h10);
      write_rate(4'd6, 8'h20);
      tick();
      tick();
      chk("busy_pend", 32'(Pend), 32'd1);
      chk("busy_ps",   32'(PS),   32'd3);
      chk("busy_div",  32'(Div),  32'h40);
      chk("busy_rdy",  32'(Rdy),  32'd0);
      Idle = 1'b1;
      tick();
      chk("busy_ps_new",  32'(PS),      32'd6);
      chk("busy_div_new", 32'(Div),     32'h20);
      chk("busy_brg",     32'(BRG_Rst), 32'd1);
      tick();
      tick();
      CE_16x = 1'b1;
      tick();
      CE_16x = 1'b0;
      chk("busy_rdy1", 32'(Rdy), 32'd1);

      // WE together with Idle in PEND delays HOLD by one cycle
      Idle = 1'b0;
      write_rate(4'd7, 8'h55);
      Idle = 1'b1;
      write_rate(4'd8, 8'h66);
      chk("race_brg0", 32'(BRG_Rst), 32'd0);
      chk("race_ps",   32'(PS),      32'd6);
      tick();
      chk("race_brg1", 32'(BRG_Rst), 32'd1);
      chk("race_ps8",  32'(PS),      32'd8);
      chk("race_div",  32'(Div),     32'h66);

      // WE during HOLD: length unchanged, lands in PEND after SYNC
      Idle = 1'b0;
      write_rate(4'd9, 8'h77);
      chk("hold_brg",  32'(BRG_Rst), 32'd1);
      chk("hold_pend", 32'(Pend),    32'd1);
      tick();
      chk("hold_len",  32'(BRG_Rst), 32'd0);
      CE_16x = 1'b1;
      tick();
      CE_16x = 1'b0;
      chk("hold_rdy0",  32'(Rdy),  32'd0);
      chk("hold_pend1", 32'(Pend), 32'd1);
      chk("hold_ps",    32'(PS),   32'd8);
      tick();
      chk("hold_stuck", 32'(Rdy),  32'd0);
      Idle = 1'b1;
      tick();
      chk("hold_ps9",  32'(PS),  32'd9);
      chk("hold_div",  32'(Div), 32'h77);
      tick();
      tick();
      CE_16x = 1'b1;
      tick();
      CE_16x = 1'b0;
      chk("hold_run", 32'(Rdy), 32'd1);

      // Mid-operation reset drops the pending request
      Idle = 1'b0;
      write_rate(4'd10, 8'h88);
      chk("mr_pend1", 32'(Pend), 32'd1);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      chk("mr_pend0", 32'(Pend),    32'd0);
      chk("mr_ps",    32'(PS),      32'd1);
      chk("mr_div",   32'(Div),     32'd12);
      chk("mr_brg",   32'(BRG_Rst), 32'd1);
      chk("mr_rdy",   32'(Rdy),     32'd0);
      Idle = 1'b1;
      tick();
      tick();
      CE_16x = 1'b1;
      tick();
      CE_16x = 1'b0;
      chk("mr_rdy1",  32'(Rdy),  32'd1);
      chk("mr_pend",  32'(Pend), 32'd0);
      chk("mr_ps_k",  32'(PS),   32'd1);
      tick();
      chk("mr_stay",  32'(Rdy),  32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
      $finish;
   end

endmodule
